// File: rtl/neuron_mac_if.sv
// Bundle of the neuron's data-side signals: activation stream, weight memory
// read port, bias, and the registered result.
interface neuron_mac_if #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10
);
  logic signed [dataWidth-1:0] myinput;
  logic                        myinputValid;
  logic                        ren;
  logic        [addressWidth:0] raddr;
  logic signed [dataWidth-1:0] wout;
  logic signed [dataWidth-1:0] bias;
  logic signed [dataWidth-1:0] out;
  logic                        outvalid;

  modport master (
    output myinput, myinputValid, wout, bias,
    input  ren, raddr, out, outvalid
  );

  modport slave (
    input  myinput, myinputValid, wout, bias,
    output ren, raddr, out, outvalid
  );
endinterface

// File: rtl/neuron_mac.sv
// Fixed-point neuron: streams numWeight input*weight products into a saturating
// accumulator, adds the bias once the pipeline drains, and emits one result.
module neuron_mac #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10,
  parameter int numWeight    = 784,
  parameter int fracBits     = 8
) (
  input  logic         clk,
  input  logic         rst,
  neuron_mac_if.slave  macBus
);

  localparam int AccW = 2 * dataWidth;
  localparam logic [addressWidth:0]  LastAddr = (addressWidth + 1)'(numWeight - 1);
  localparam logic signed [AccW-1:0] AccMax   = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] AccMin   = {1'b1, {(AccW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} stateT;

  stateT                       state_q, state_d;
  logic        [addressWidth:0] raddr_q, raddr_d;
  logic                        drainCnt_q;
  logic signed [dataWidth-1:0] inputD_q;
  logic                        inputValid_q;
  logic signed [AccW-1:0]      prod_q;
  logic                        prodValid_q;
  logic signed [AccW-1:0]      acc_q;
  logic signed [dataWidth-1:0] out_q;
  logic                        outvalid_q;

  logic                        accept;
  logic                        frameStart;
  logic signed [AccW-1:0]      prodFull;
  logic signed [AccW-1:0]      biasExt;
  logic signed [AccW-1:0]      doneSum;
  logic signed [AccW-1:0]      shifted;
  logic signed [dataWidth-1:0] outSat;

  // Clamp on two's-complement overflow: like-signed operands must keep their sign.
  function automatic logic signed [AccW-1:0] satAdd(input logic signed [AccW-1:0] a,
                                                    input logic signed [AccW-1:0] b);
    logic signed [AccW-1:0] s;
    s = a + b;
    if (!a[AccW-1] && !b[AccW-1] && s[AccW-1]) return AccMax;
    if (a[AccW-1] && b[AccW-1] && !s[AccW-1]) return AccMin;
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = macBus.myinputValid;
        if (accept) state_d = (numWeight == 1) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        accept = macBus.myinputValid;
        if (accept && raddr_q == LastAddr) state_d = DRAIN;
      end
      DRAIN: begin
        if (drainCnt_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) raddr_d = (raddr_q == LastAddr) ? '0 : raddr_q + 1'b1;
  end

  assign frameStart = accept && (state_q == IDLE);
  assign prodFull   = AccW'(inputD_q) * AccW'(macBus.wout);
  assign biasExt    = AccW'(macBus.bias) <<< fracBits;
  assign doneSum    = satAdd(acc_q, biasExt);
  assign shifted    = doneSum >>> fracBits;

  // Narrow to dataWidth only if every discarded high bit matches the sign bit.
  always_comb begin
    outSat = shifted[dataWidth-1:0];
    if (!(&shifted[AccW-1:dataWidth-1]) && (|shifted[AccW-1:dataWidth-1]))
      outSat = shifted[AccW-1] ? {1'b1, {(dataWidth-1){1'b0}}}
                               : {1'b0, {(dataWidth-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      raddr_q      <= '0;
      drainCnt_q   <= 1'b0;
      inputD_q     <= '0;
      inputValid_q <= 1'b0;
      prod_q       <= '0;
      prodValid_q  <= 1'b0;
      acc_q        <= '0;
      out_q        <= '0;
      outvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      drainCnt_q   <= (state_q == DRAIN) ? ~drainCnt_q : 1'b0;
      inputValid_q <= accept;
      if (accept) inputD_q <= macBus.myinput;
      prodValid_q  <= inputValid_q;
      if (inputValid_q) prod_q <= prodFull;
      // The last product lands in acc_q exactly as the FSM enters DONE.
      if (frameStart)       acc_q <= '0;
      else if (prodValid_q) acc_q <= satAdd(acc_q, prod_q);
      outvalid_q   <= (state_q == DONE);
      if (state_q == DONE) out_q <= outSat;
    end
  end

  assign macBus.ren      = accept;
  assign macBus.raddr    = raddr_q;
  assign macBus.out      = out_q;
  assign macBus.outvalid = outvalid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac (numWeight=4): directed and random frames
// compared against an arithmetic reference of the fixed-point neuron.
module tb_neuron_mac;

  localparam int NW = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  logic signed [15:0] curIn [NW];
  logic signed [15:0] curW  [NW];
  logic signed [15:0] curBias;

  int   expVal[$];
  int   expCyc[$];
  int   obsVal[$];
  int   obsCyc[$];

  neuron_mac_if #(.dataWidth(16), .addressWidth(10)) macBus ();

  neuron_mac #(
    .dataWidth(16), .addressWidth(10), .numWeight(NW), .fracBits(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .macBus (macBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Registered weight memory: data appears the cycle after ren.
  always @(posedge clk)
    if (macBus.ren) macBus.wout <= (macBus.raddr < 11'(NW)) ? curW[macBus.raddr[1:0]] : 16'sd0;

  always @(negedge clk)
    if (macBus.outvalid) begin
      obsVal.push_back(int'(macBus.out));
      obsCyc.push_back(cyc);
    end

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [15:0] refNeuron();
    longint acc;
    acc = 0;
    for (int i = 0; i < NW; i++)
      acc = sat(acc + longint'(curIn[i]) * longint'(curW[i]), 32);
    acc = sat(acc + longint'(curBias) * 256, 32);
    acc = acc >>> 8;
    acc = sat(acc, 16);
    return acc[15:0];
  endfunction

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one frame; gapLen idle cycles before input gapAt, then hold cycles of
  // junk with myinputValid high that the DUT must ignore.
  task automatic applyStimulus(input int gapAt, input int gapLen, input int hold);
    int lastCyc;
    logic signed [15:0] expOut;
    expOut = refNeuron();
    macBus.bias = curBias;
    lastCyc = 0;
    for (int i = 0; i < NW; i++) begin
      if (i == gapAt)
        for (int g = 0; g < gapLen; g++) begin
          macBus.myinputValid = 1'b0;
          #1 checkOutput("stallAddr", longint'(macBus.raddr), longint'(i));
          @(negedge clk);
        end
      macBus.myinput      = curIn[i];
      macBus.myinputValid = 1'b1;
      #1;
      checkOutput("renAccept", longint'(macBus.ren), 1);
      checkOutput("raddrSeq", longint'(macBus.raddr), longint'(i));
      if (i == NW - 1) lastCyc = cyc;
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      macBus.myinput      = 16'($urandom);
      macBus.myinputValid = 1'b1;
      #1;
      checkOutput("renIgnored", longint'(macBus.ren), 0);
      checkOutput("raddrWrap", longint'(macBus.raddr), 0);
      @(negedge clk);
    end
    macBus.myinputValid = 1'b0;
    expVal.push_back(int'(expOut));
    expCyc.push_back(lastCyc + 4);
  endtask

  task automatic drainResults();
    int n;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("resultCount", longint'(obsVal.size()), longint'(expVal.size()));
    n = (obsVal.size() < expVal.size()) ? obsVal.size() : expVal.size();
    for (int k = 0; k < n; k++) begin
      checkOutput("outValue", longint'(obsVal[k]), longint'(expVal[k]));
      checkOutput("outCycle", longint'(obsCyc[k]), longint'(expCyc[k]));
    end
    checkOutput("outvalidPulse", longint'(macBus.outvalid), 0);
    obsVal.delete(); obsCyc.delete(); expVal.delete(); expCyc.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    macBus.myinput      = '0;
    macBus.myinputValid = 1'b0;
    macBus.bias         = '0;
    macBus.wout         = '0;
    for (int i = 0; i < NW; i++) begin curIn[i] = '0; curW[i] = '0; end
    curBias = '0;

    repeat (3) @(negedge clk);
    checkOutput("resetOut", longint'(macBus.out), 0);
    checkOutput("resetOutvalid", longint'(macBus.outvalid), 0);
    checkOutput("resetRaddr", longint'(macBus.raddr), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame, then the same frame with a three-cycle input gap.
    for (int i = 0; i < NW; i++) begin curIn[i] = 16'sh0100; curW[i] = 16'((i + 1) * 256); end
    curBias = 16'sh0080;
    applyStimulus(-1, 0, 0);
    drainResults();
    applyStimulus(2, 3, 0);
    drainResults();

    // Positive and negative saturation.
    for (int i = 0; i < NW; i++) begin curIn[i] = 16'sh7FFF; curW[i] = 16'sh7FFF; end
    curBias = 16'sh7FFF;
    applyStimulus(-1, 0, 0);
    drainResults();
    for (int i = 0; i < NW; i++) curIn[i] = -16'sh7FFF;
    applyStimulus(-1, 0, 0);
    drainResults();

    // Reset in mid-frame abandons it; the next frame restarts at address 0.
    for (int i = 0; i < NW; i++) begin curIn[i] = 16'sh0100; curW[i] = 16'sh0100; end
    curBias = 16'sh0000;
    macBus.bias = curBias;
    for (int i = 0; i < 2; i++) begin
      macBus.myinput = curIn[i];
      macBus.myinputValid = 1'b1;
      @(negedge clk);
    end
    macBus.myinputValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("abortRaddr", longint'(macBus.raddr), 0);
    repeat (8) @(negedge clk);
    checkOutput("abortNoResult", longint'(obsVal.size()), 0);
    applyStimulus(-1, 0, 0);
    drainResults();

    // Valid held through DRAIN/DONE, then an immediate back-to-back frame.
    curIn[0] = 16'sh0200; curIn[1] = -16'sh0100; curIn[2] = 16'sh0040; curIn[3] = 16'sh0010;
    curW[0]  = 16'sh0180; curW[1]  = 16'sh0300;  curW[2]  = -16'sh0500; curW[3] = 16'sh0020;
    curBias = -16'sh0123;
    applyStimulus(-1, 0, 3);
    for (int i = 0; i < NW; i++) begin curIn[i] = 16'sh0111 * 16'(i + 1); curW[i] = 16'sh0101; end
    curBias = 16'sh0042;
    applyStimulus(-1, 0, 0);
    drainResults();

    // Random frames: moderate magnitudes most of the time, full range sometimes.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NW; i++) begin
        if (f % 3 == 2) begin
          curIn[i] = 16'($urandom);
          curW[i]  = 16'($urandom);
        end else begin
          curIn[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
          curW[i]  = 16'(int'($urandom_range(0, 4095)) - 2048);
        end
      end
      curBias = 16'($urandom);
      applyStimulus(int'($urandom_range(0, NW)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      drainResults();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001: The module SHALL have parameter dataWidth, default 16, setting the width of the signed input, weight, bias and output words.
REQ-002: The module SHALL have parameter addressWidth, default 10, setting the weight address width; raddr is addressWidth+1 bits.
REQ-003: The module SHALL have parameter numWeight, default 784, setting the number of input/weight products per frame (1..2**addressWidth).
REQ-004: The module SHALL have parameter fracBits, default 8, setting the fractional bits of the fixed-point format (Q(dataWidth-fracBits).fracBits).
REQ-005: clk  in  1  sole clock; all state updates on the rising edge.
REQ-006: rst  in  1  reset, synchronous, active-high.
REQ-007: myinput  in  dataWidth  signed input activation.
REQ-008: myinputValid  in  1  myinput valid this cycle; there is no backpressure.
REQ-009: ren  out  1  weight memory read enable, combinationally equal to myinputValid while in IDLE or ACCUM, else 0.
REQ-010: raddr  out  addressWidth+1  weight read address, registered counter.
REQ-011: wout  in  dataWidth  signed weight, valid one cycle after ren (registered memory read).
REQ-012: bias  in  dataWidth  signed bias in the same Q format as myinput, held static during operation.
REQ-013: out  out  dataWidth  signed neuron pre-activation result, registered.
REQ-014: outvalid  out  1  single-cycle pulse qualifying out.

Function
REQ-015: The FSM SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-016: In IDLE, an accepted input SHALL go to ACCUM (or DRAIN if numWeight==1).
REQ-017: In ACCUM, the numWeight-th accepted input SHALL go to DRAIN.
REQ-018: DRAIN SHALL last exactly 2 cycles, then go to DONE.
REQ-019: DONE SHALL last 1 cycle, then go to IDLE.
REQ-020: Each accepted input SHALL increment raddr by 1; after the numWeight-th input raddr SHALL return to 0.
REQ-021: myinput SHALL be delayed one register stage so that it pairs with the wout read at the same address.
REQ-022: Products SHALL be full-precision 2*dataWidth-bit signed values, registered one cycle after the weight arrives.
REQ-023: The accumulator SHALL be 2*dataWidth bits signed, cleared at frame start, and add each registered product.
REQ-024: Accumulator additions SHALL saturate: pos+pos giving negative clamps to max positive; neg+neg giving non-negative clamps to max negative.
REQ-025: In DONE, bias SHALL be sign-extended and shifted left by fracBits, then added to the accumulator with the same saturation.
REQ-026: The DONE sum SHALL be arithmetically shifted right by fracBits, saturated to dataWidth signed, and registered to out.
REQ-027: outvalid SHALL be high exactly in the cycle L+4, where L is the cycle holding the last accepted input.
REQ-028: out SHALL hold its value until the next outvalid.
REQ-029: Inputs gaps (myinputValid low) in ACCUM SHALL stall the counter and pipeline with no effect on the result.
REQ-030: myinputValid in DRAIN or DONE SHALL be ignored: ren=0, no counter advance, no accumulation.
REQ-031: Back-to-back frames SHALL be accepted from IDLE on the cycle after DONE.

Reset
REQ-032: While rst is high, the state SHALL be IDLE and raddr, accumulator, pipeline registers, out and outvalid SHALL all be 0.
REQ-033: rst asserted mid-frame SHALL abandon the partial frame with no outvalid; the next accepted input SHALL start a new frame at raddr 0.

Verification (numWeight=4, fracBits=8, dataWidth=16)
REQ-034: Verification: inputs 0x0100 x4, weights 0x0100,0x0200,0x0300,0x0400, bias 0x0080 -> out=0x0A80, outvalid single pulse at L+4; raddr sequence 0,1,2,3,0.
REQ-035: Verification: same frame with myinputValid low for 3 cycles between inputs 2 and 3 -> identical out=0x0A80, outvalid 4 cycles after last input.
REQ-036: Verification: inputs 0x7FFF x4, weights 0x7FFF, bias 0x7FFF -> out=0x7FFF (positive saturation); negate inputs -> out=0x8000.
REQ-037: Verification: rst pulsed after 2 inputs, then a full frame of inputs 0x0100/weights 0x0100, bias 0 -> no outvalid for the aborted frame; out=0x0400.
REQ-038: Verification: myinputValid held high through DRAIN/DONE -> those inputs ignored with ren=0; a second frame starting after DONE gives the correct independent result.
